poco_mem_arb: RTL

Single-port memory arbiter that shares one synchronous unified RAM between the POCO instruction-fetch port, the POCO data (LD/ST) port, and an external host port used for program loading and debug. Each cycle it grants at most one requester, drives the RAM, and routes the one-cycle-latency read data back to the owner. It also provides anti-starvation aging and a host bus lock, so the host can halt the CPU between instructions.

---
 rtl/poco_mem_arb.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/poco_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : poco_mem_arb
//  Purpose  : Single-port memory arbiter sharing one synchronous unified RAM
//             between the POCO fetch port (if_*), the POCO data port (d_*)
//             and an external host port (h_*). At most one requester is
//             granted per cycle; read data returns one cycle after the grant
//             and is steered to the port that issued the read.
//  Ports    : clk, rst_n        - clock, synchronous active-low reset
//             if_*              - fetch read port (req/addr -> gnt/rvalid/rdata)
//             d_*               - data read/write port
//             h_*               - host read/write port with bus lock (h_lock)
//             mem_*             - RAM command out, mem_rdata in (1-cycle latency)
//             cpu_stall         - a CPU port is requesting but not granted
//  Config   : POCO_ARB_RR_EN defined   -> round-robin d->if->h in ARB state
//             POCO_ARB_RR_EN undefined -> fixed priority d>if>h with aging
//  Revision : 1.0 - initial release
// ============================================================================
module poco_mem_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // host port
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_lock,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    // RAM command
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2, OWN_H = 2'd3} owner_t;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;

    // Requester index: 0 = data, 1 = fetch, 2 = host (default priority order)
    logic [2:0] w_req;
    logic [2:0] w_gnt_raw;
    logic [2:0] w_gnt;
    logic       w_lock_hold;

    assign w_req = {h_req, if_req, d_req};

    // Lock persists while the host keeps h_lock high; once it is sampled low
    // the same cycle falls back to normal arbitration.
    assign w_lock_hold = (state_q == ST_LOCK) && h_lock;

`ifdef POCO_ARB_RR_EN
    // Last granted requester; resets to host so data is served first.
    logic [1:0] last_q, last_d;

    always_comb begin
        w_gnt_raw = 3'b000;
        if (w_lock_hold) begin
            w_gnt_raw[2] = h_req;
        end else begin
            case (last_q)
                2'd0: begin // last = d -> if, h, d
                    if      (w_req[1]) w_gnt_raw[1] = 1'b1;
                    else if (w_req[2]) w_gnt_raw[2] = 1'b1;
                    else if (w_req[0]) w_gnt_raw[0] = 1'b1;
                end
                2'd1: begin // last = if -> h, d, if
                    if      (w_req[2]) w_gnt_raw[2] = 1'b1;
                    else if (w_req[0]) w_gnt_raw[0] = 1'b1;
                    else if (w_req[1]) w_gnt_raw[1] = 1'b1;
                end
                default: begin // last = h -> d, if, h
                    if      (w_req[0]) w_gnt_raw[0] = 1'b1;
                    else if (w_req[1]) w_gnt_raw[1] = 1'b1;
                    else if (w_req[2]) w_gnt_raw[2] = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (w_gnt[0])      last_d = 2'd0;
        else if (w_gnt[1]) last_d = 2'd1;
        else if (w_gnt[2]) last_d = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [2:0][3:0] cnt_q, cnt_d;
    logic [2:0]      w_elev;

    // A waiting requester that has hit the limit jumps ahead of everyone
    // not yet elevated; elevation is ignored while the host holds the lock.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_elev[i] = w_req[i] && (cnt_q[i] == STARVE_LIM);
        end
    end

    always_comb begin
        w_gnt_raw = 3'b000;
        if (w_lock_hold) begin
            w_gnt_raw[2] = h_req;
        end else if (|w_elev) begin
            if      (w_elev[0]) w_gnt_raw[0] = 1'b1;
            else if (w_elev[1]) w_gnt_raw[1] = 1'b1;
            else                w_gnt_raw[2] = 1'b1;
        end else begin
            if      (w_req[0]) w_gnt_raw[0] = 1'b1;
            else if (w_req[1]) w_gnt_raw[1] = 1'b1;
            else if (w_req[2]) w_gnt_raw[2] = 1'b1;
        end
    end

    // Counters run in every state, including LOCK.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (!w_req[i] || w_gnt[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] != STARVE_LIM) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Grants are suppressed combinationally while reset is asserted.
    assign w_gnt  = rst_n ? w_gnt_raw : 3'b000;
    assign d_gnt  = w_gnt[0];
    assign if_gnt = w_gnt[1];
    assign h_gnt  = w_gnt[2];

    assign cpu_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);

    // RAM command mux; idle bus drives zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[0]) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_gnt[1]) begin
            mem_addr  = if_addr;
        end else if (w_gnt[2]) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    assign mem_en = |w_gnt;

    // State and read-owner next values
    always_comb begin
        state_d = (w_lock_hold || (w_gnt[2] && h_lock)) ? ST_LOCK : ST_ARB;
        owner_d = OWN_NONE;
        if (w_gnt[0] && !d_we)      owner_d = OWN_D;
        else if (w_gnt[1])          owner_d = OWN_IF;
        else if (w_gnt[2] && !h_we) owner_d = OWN_H;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Read return steering
    assign if_rvalid = rst_n && (owner_q == OWN_IF);
    assign d_rvalid  = rst_n && (owner_q == OWN_D);
    assign h_rvalid  = rst_n && (owner_q == OWN_H);

    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid  ? mem_rdata : '0;
    assign h_rdata  = h_rvalid  ? mem_rdata : '0;

endmodule
`default_nettype wire
